// File: rtl/input_debouncer_bank.sv
// input_debouncer_bank: N independent counter debouncers with registered rise/fall pulses.
// Define INPUT_DEBOUNCER_REPEAT_EN to build the per-channel auto-repeat counters.
module input_debouncer_bank #(
  parameter int N         = 8,
  parameter int DIV       = 25000,
  parameter int CW        = 16,
  parameter int REP_DELAY = 12500000,
  parameter int REP_RATE  = 2500000
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] load_i,
  input  logic [N-1:0] data_i,
  input  logic [N-1:0] btn_i,
  output logic [N-1:0] q_o,
  output logic [N-1:0] rise_o,
  output logic [N-1:0] fall_o,
  output logic [N-1:0] rpt_o,
  output logic         any_edge_o
);

  localparam logic [CW-1:0] DV = (DIV == 0) ? '0 : CW'(DIV - 1);
`ifdef INPUT_DEBOUNCER_REPEAT_EN
  localparam logic [CW-1:0] RD = (REP_DELAY == 0) ? '0 : CW'(REP_DELAY - 1);
  localparam logic [CW-1:0] RR = (REP_RATE == 0) ? '0 : CW'(REP_RATE - 1);
`endif

  logic [N-1:0] rise_next;
  logic [N-1:0] fall_next;
  logic         any_edge_q;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      logic [CW-1:0] cnt_q, cnt_d;
      logic          q_q, q_d;
      logic          rise_q, rise_d;
      logic          fall_q, fall_d;

      // Load beats agreement, agreement beats countdown; a toggle fires only from cnt==0.
      always_comb begin
        cnt_d  = cnt_q;
        q_d    = q_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (load_i[gi]) begin
          q_d   = data_i[gi];
          cnt_d = DV;
        end else if (btn_i[gi] == q_q) begin
          cnt_d = DV;
        end else if (cnt_q == '0) begin
          q_d    = ~q_q;
          rise_d = ~q_q;
          fall_d = q_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cnt_q  <= DV;
          q_q    <= 1'b0;
          rise_q <= 1'b0;
          fall_q <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          q_q    <= q_d;
          rise_q <= rise_d;
          fall_q <= fall_d;
        end
      end

      assign q_o[gi]       = q_q;
      assign rise_o[gi]    = rise_q;
      assign fall_o[gi]    = fall_q;
      assign rise_next[gi] = rise_d;
      assign fall_next[gi] = fall_d;

`ifdef INPUT_DEBOUNCER_REPEAT_EN
      logic [CW-1:0] rcnt_q, rcnt_d;
      logic          ract_q, ract_d;
      logic          rpt_q, rpt_d;

      // Armed by the debounced press; any release, low level or load drops back to idle.
      always_comb begin
        rcnt_d = rcnt_q;
        ract_d = ract_q;
        rpt_d  = 1'b0;
        if (rise_d) begin
          ract_d = 1'b1;
          rcnt_d = RD;
        end else if (load_i[gi] || !q_q || !btn_i[gi]) begin
          ract_d = 1'b0;
        end else if (ract_q) begin
          if (rcnt_q == '0) begin
            rpt_d  = 1'b1;
            rcnt_d = RR;
          end else begin
            rcnt_d = rcnt_q - 1'b1;
          end
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          rcnt_q <= '0;
          ract_q <= 1'b0;
          rpt_q  <= 1'b0;
        end else begin
          rcnt_q <= rcnt_d;
          ract_q <= ract_d;
          rpt_q  <= rpt_d;
        end
      end

      assign rpt_o[gi] = rpt_q;
`else
      assign rpt_o[gi] = 1'b0;
`endif
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      any_edge_q <= 1'b0;
    end else begin
      any_edge_q <= |(rise_next | fall_next);
    end
  end

  assign any_edge_o = any_edge_q;

endmodule

// File: tb/tb_input_debouncer_bank.sv
// Directed bench for input_debouncer_bank (N=4, DIV=4, REP_DELAY=10, REP_RATE=3).
// Repeat expectations follow INPUT_DEBOUNCER_REPEAT_EN as seen by this file.
module tb_input_debouncer_bank;

`ifdef INPUT_DEBOUNCER_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] load = '0, data = '0, btn = '0;
  logic [3:0] q, rise, fall, rpt;
  logic       any_edge;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] load, data, btn, q, rise, fall;
    logic       any;
  } vec_t;

  vec_t tbl[27];

  input_debouncer_bank #(.N(4), .DIV(4), .CW(16), .REP_DELAY(10), .REP_RATE(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .load_i(load), .data_i(data), .btn_i(btn),
    .q_o(q), .rise_o(rise), .fall_o(fall), .rpt_o(rpt), .any_edge_o(any_edge)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] eq, input logic [3:0] er,
                           input logic [3:0] ef, input logic [3:0] ep, input logic ea);
    check({tag, " q"}, 32'(q), 32'(eq));
    check({tag, " rise"}, 32'(rise), 32'(er));
    check({tag, " fall"}, 32'(fall), 32'(ef));
    check({tag, " rpt"}, 32'(rpt), 32'(ep));
    check({tag, " any_edge"}, 32'(any_edge), 32'(ea));
  endtask

  initial begin
    // {load, data, btn, q, rise, fall, any}
    tbl[0]  = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[1]  = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[2]  = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[3]  = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 1'b1};
    tbl[4]  = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0};
    tbl[5]  = '{4'h0, 4'h0, 4'h2, 4'h1, 4'h0, 4'h0, 1'b0};
    tbl[6]  = '{4'h0, 4'h0, 4'h2, 4'h1, 4'h0, 4'h0, 1'b0};
    tbl[7]  = '{4'h0, 4'h0, 4'h2, 4'h1, 4'h0, 4'h0, 1'b0};
    tbl[8]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 1'b1};
    tbl[9]  = '{4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[10] = '{4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[11] = '{4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[12] = '{4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 1'b1};
    tbl[13] = '{4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 1'b0};
    tbl[14] = '{4'h4, 4'h4, 4'h2, 4'h6, 4'h0, 4'h0, 1'b0};
    tbl[15] = '{4'h0, 4'h0, 4'h2, 4'h6, 4'h0, 4'h0, 1'b0};
    tbl[16] = '{4'h0, 4'h0, 4'h2, 4'h6, 4'h0, 4'h0, 1'b0};
    tbl[17] = '{4'h0, 4'h0, 4'h2, 4'h6, 4'h0, 4'h0, 1'b0};
    tbl[18] = '{4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 1'b1};
    tbl[19] = '{4'h2, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[20] = '{4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[21] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[22] = '{4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[23] = '{4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[24] = '{4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[25] = '{4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0, 1'b1};
    tbl[26] = '{4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0};

    // Held in reset across two edges, then released away from the clock edge.
    step();
    step();
    check_all("in_reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 20; c++) begin
      btn = 4'h0;
      step();
      check_all("idle", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    end
    $display("idle: 20 cycles with btn=0");

    for (int v = 0; v < 27; v++) begin
      load = tbl[v].load;
      data = tbl[v].data;
      btn  = tbl[v].btn;
      step();
      check_all($sformatf("vec%0d", v), tbl[v].q, tbl[v].rise, tbl[v].fall, 4'h0, tbl[v].any);
      $display("vec %0d: load=%h data=%h btn=%h -> q=%h rise=%h fall=%h rpt=%h any=%b",
               v, load, data, btn, q, rise, fall, rpt, any_edge);
    end
    load = '0;

    // All four channels rose at vec25 (k=0); auto-repeat at k=10, 13, 16, ...
    for (int k = 2; k <= 30; k++) begin
      logic [3:0] ep;
      btn = 4'hF;
      step();
      ep = (REP && k >= 10 && ((k - 10) % 3) == 0) ? 4'hF : 4'h0;
      check_all($sformatf("repeat k%0d", k), 4'hF, 4'h0, 4'h0, ep, 1'b0);
      $display("repeat k=%0d: q=%h rpt=%h", k, q, rpt);
    end

    // Releasing btn[3] idles its repeat counter while channels 0..2 still pulse.
    btn = 4'h7;
    step();
    check_all("release3", 4'hF, 4'h0, 4'h0, REP ? 4'h7 : 4'h0, 1'b0);
    $display("release ch3: q=%h rpt=%h", q, rpt);

    // Asynchronous reset clears outputs without waiting for a clock edge.
    btn = 4'h0;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    $display("async reset: q=%h", q);
    @(negedge clk);
    btn = 4'h1;
    rst_n = 1'b1;

    step();
    check("midcount e1 q", 32'(q), 32'h0);
    step();
    check("midcount e2 q", 32'(q), 32'h0);
    rst_n = 1'b0;
    #1;
    check_all("midcount reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      check_all($sformatf("restart e%0d", e), 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      $display("restart edge %0d: q=%h", e, q);
    end
    step();
    check_all("restart e4", 4'h1, 4'h1, 4'h0, 4'h0, 1'b1);
    $display("restart edge 4: q=%h rise=%h any=%b", q, rise, any_edge);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
